// File: rtl/bcd_display_scanner_pkg.sv
// Shared segment constants for the multiplexed 7-segment driver.
package bcd_display_scanner_pkg;

   // Segment order {g,f,e,d,c,b,a}, active-low: a 0 bit lights the segment.
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   // BCD -> segment table; codes 10..15 are not BCD and show a dash.
   localparam logic [6:0] SEG_LUT [16] = '{
      7'b1000000,  // 0
      7'b1111001,  // 1
      7'b0100100,  // 2
      7'b0110000,  // 3
      7'b0011001,  // 4
      7'b0010010,  // 5
      7'b0000010,  // 6
      7'b1111000,  // 7
      7'b0000000,  // 8
      7'b0010000,  // 9
      SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
   };

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Counter-side digit bus plus board-side pin bundle for the display scanner.
interface bcd_display_scanner_if #(
   parameter int N_DIG = 4
);
   logic [4*N_DIG-1:0] digits_in;
   logic               blank_lead;
   logic               blink_en;
   logic [N_DIG-1:0]   blink_mask;
   logic [N_DIG-1:0]   dp_mask;
   logic [N_DIG-1:0]   an;
   logic [6:0]         seg;
   logic               dp;

   // Master supplies digits and display controls, observes the pins.
   modport master (
      output digits_in, blank_lead, blink_en, blink_mask, dp_mask,
      input  an, seg, dp
   );

   // Slave is the scanner itself.
   modport slave (
      input  digits_in, blank_lead, blink_en, blink_mask, dp_mask,
      output an, seg, dp
   );
endinterface

// File: rtl/bcd_display_scanner_bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment pattern.
module bcd_to_7seg
   import bcd_display_scanner_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   assign seg = SEG_LUT[bcd];

endmodule

// File: rtl/bcd_display_scanner.sv
// Multiplexed common-anode 7-segment scanner. A per-frame snapshot of the
// digit bus keeps a mid-scan count change from showing a torn value; each
// slot starts with a short all-off guard to suppress ghosting.
module bcd_display_scanner
   import bcd_display_scanner_pkg::*;
#(
   parameter int N_DIG       = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int GUARD       = 16,
   parameter int BLINK_BITS  = 25
) (
   input logic                  clk,
   input logic                  reset,
   bcd_display_scanner_if.slave bus
);

   localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

   logic [DIV_W-1:0]      div;
   logic [IDX_W-1:0]      idx;
   logic [4*N_DIG-1:0]    snap;
   logic [BLINK_BITS-1:0] blink_cnt;

   logic                  tick;
   logic                  last_slot;
   logic [3:0]            cur_digit;
   logic                  blink_bit;
   logic                  dp_bit;
   logic [N_DIG-1:0]      an_act;
   logic [6:0]            seg_dec;
   logic                  slot_off;

   logic [N_DIG-1:0]      an_q;
   logic [6:0]            seg_q;
   logic                  dp_q;

   assign tick      = (div == DIV_W'(REFRESH_DIV - 1));
   assign last_slot = (idx == IDX_W'(N_DIG - 1));

   // Slot timer, scan index, frame snapshot and free-running blink counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         div       <= '0;
         idx       <= '0;
         snap      <= '0;
         blink_cnt <= '0;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
         if (tick) begin
            div <= '0;
            idx <= last_slot ? '0 : idx + 1'b1;
            // Capture at the frame boundary so the next frame is consistent.
            if (last_slot) snap <= bus.digits_in;
         end else begin
            div <= div + 1'b1;
         end
      end
   end

   // Select the current slot's digit, mask bits and anode pattern.
   always_comb begin
      cur_digit = 4'd0;
      blink_bit = 1'b0;
      dp_bit    = 1'b0;
      an_act    = '1;
      for (int i = 0; i < N_DIG; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_digit = snap[4*i +: 4];
            blink_bit = bus.blink_mask[i];
            dp_bit    = bus.dp_mask[i];
            an_act[i] = 1'b0;
         end
      end
   end

   bcd_to_7seg u_dec (
      .bcd (cur_digit),
      .seg (seg_dec)
   );

   // Guard window, blink-off phase and leading-zero blanking all dark the slot.
   assign slot_off = (div < DIV_W'(GUARD))
                   | (bus.blink_en & blink_cnt[BLINK_BITS-1] & blink_bit)
                   | (bus.blank_lead & last_slot & (cur_digit == 4'd0));

   // Registered pins: one cycle behind the scan state.
   always_ff @(posedge clk) begin
      if (reset || slot_off) begin
         an_q  <= '1;
         seg_q <= SEG_BLANK;
         dp_q  <= 1'b1;
      end else begin
         an_q  <= an_act;
         seg_q <= seg_dec;
         dp_q  <= ~dp_bit;
      end
   end

   assign bus.an  = an_q;
   assign bus.seg = seg_q;
   assign bus.dp  = dp_q;

endmodule
